ifetch_stage: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of decode.
- Owns PCF and the IF/ID pipeline register, and drives the instruction-memory request port. Memory has variable latency.
- Produces InstrD, PCD and PCPlus4D for decode.
- Handles hazard stall, decode flush and branch/jump redirect from execute, including a redirect that arrives while a memory access is still outstanding.

---
 rtl/ifetch_stage.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns PCF and the IF/ID register. It drives a variable-latency instruction
// memory port and holds ImemAddr stable while an access is outstanding.
// A small three-state controller handles the cases where the fetched word
// cannot be used directly:
//   RUN  - normal fetch. A word arriving with no stall goes straight to IF/ID.
//   KILL - a redirect arrived while an access was still in flight. The
//          access must complete on its original address, and its word is
//          then discarded.
//   HOLD - a word arrived while decode was stalled. It is parked in a
//          one-entry buffer, and no new request is issued until decode
//          accepts it.

module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  input  logic        ImemReady,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    KILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Where the IF/ID register takes its contents from when it is neither
  // flushed nor stalled.
  typedef enum logic [1:0] {
    SRC_BUBBLE = 2'd0,
    SRC_MEM    = 2'd1,
    SRC_BUF    = 2'd2
  } ifid_src_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pcf;
  logic [31:0] pcf_next;
  logic [31:0] pcf_plus4;
  logic [31:0] saved_target;
  logic [31:0] saved_target_next;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        buf_we;
  ifid_src_t   ifid_src;
  logic [31:0] target;

  // Redirect targets are always word-aligned. The low two bits are masked
  // here rather than sliced off, so every input bit stays in use.
  assign target    = PCTargetE & ~32'h0000_0003;
  assign pcf_plus4 = pcf + 32'd4;

  // PCF only changes when an access completes or when no access is in
  // flight. PCF therefore already serves as the held address in KILL.
  assign ImemAddr  = pcf;

  // Reset forces the request low. The state register already reads RUN
  // during reset, so the state alone would otherwise assert a request.
  assign ImemReq   = reset && (state != HOLD);

  // Next-state, next-PC and IF/ID source selection for the fetch controller.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    state_next        = state;
    pcf_next          = pcf;
    saved_target_next = saved_target;
    buf_we            = 1'b0;
    ifid_src          = SRC_BUBBLE;

    case (state)
      RUN: begin
        if (PCSrcE) begin
          if (ImemReady) begin
            // The access is done but fetched the wrong path. Drop the word.
            pcf_next = target;
          end else begin
            // The access is still in flight. Its address must stay stable
            // until it completes, so the target is parked until then.
            saved_target_next = target;
            state_next        = KILL;
          end
        end else if (ImemReady) begin
          pcf_next = pcf_plus4;
          if (StallD) begin
            buf_we     = 1'b1;
            state_next = HOLD;
          end else begin
            ifid_src = SRC_MEM;
          end
        end
      end

      KILL: begin
        // The latest redirect wins, including one that arrives on the same
        // cycle as the wrong-path response.
        if (PCSrcE) begin
          saved_target_next = target;
        end
        if (ImemReady) begin
          pcf_next   = PCSrcE ? target : saved_target;
          state_next = RUN;
        end
      end

      HOLD: begin
        if (PCSrcE) begin
          // The buffered word is on the wrong path. PCF already moved past
          // it, so the redirect target replaces PCF outright.
          pcf_next   = target;
          state_next = RUN;
        end else if (!StallD) begin
          ifid_src   = SRC_BUF;
          state_next = RUN;
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Fetch controller state, PC and saved redirect target.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples its pre-edge inputs regardless of statement order.
    if (!reset) begin
      state        <= RUN;
      pcf          <= RESET_PC;
      saved_target <= 32'h0000_0000;
    end else begin
      state        <= state_next;
      pcf          <= pcf_next;
      saved_target <= saved_target_next;
    end
  end

  // One-entry skid buffer. It captures the word that completed while
  // decode was stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_instr <= 32'h0000_0000;
      buf_pc    <= 32'h0000_0000;
    end else if (buf_we) begin
      buf_instr <= ImemRdata;
      buf_pc    <= pcf;
    end
  end

  // IF/ID register. A flush beats a stall, and a stall beats the
  // controller's choice. A bubble keeps PCD/PCPlus4D unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      case (ifid_src)
        SRC_MEM: begin
          InstrD   <= ImemRdata;
          PCD      <= pcf;
          PCPlus4D <= pcf_plus4;
          ValidD   <= 1'b1;
        end
        SRC_BUF: begin
          InstrD   <= buf_instr;
          PCD      <= buf_pc;
          PCPlus4D <= buf_pc + 32'd4;
          ValidD   <= 1'b1;
        end
        default: begin
          InstrD <= NOP_INSTR;
          ValidD <= 1'b0;
        end
      endcase
    end
  end

endmodule
